// File: rtl/lenet_frame_pooler.sv
// lenet_frame_pooler: block-averages a centred window of a pixel stream into a small image and hands it to an inference engine
module lenet_frame_pooler #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int BLOCK_W   = 8,
    parameter int BLOCK_H   = 8,
    parameter int OUT_W     = 28,
    parameter int OUT_H     = 28,
    parameter int X_OFF     = 208,
    parameter int Y_OFF     = 128,
    parameter int THRESHOLD = 96,
    localparam int ACC_W    = 8 + $clog2(BLOCK_W * BLOCK_H),
    localparam int AW       = $clog2(OUT_W * OUT_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode_bin,
    input  logic          invert,
    input  logic          pix_valid,
    input  logic          pix_sof,
    input  logic [7:0]    pix_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          frame_done,
    output logic          infer_go,
    input  logic          infer_done,
    output logic          busy,
    output logic [7:0]    drop_cnt
);
    localparam int LB   = $clog2(BLOCK_W * BLOCK_H);
    localparam int LBW  = $clog2(BLOCK_W);
    localparam int LBH  = $clog2(BLOCK_H);
    localparam int XW   = $clog2(SCREEN_W + 1);
    localparam int YW   = $clog2(SCREEN_H + 1);
    localparam int CW   = OUT_W > 1 ? $clog2(OUT_W) : 1;
    localparam int RW   = OUT_H > 1 ? $clog2(OUT_H) : 1;
    localparam int LAST = OUT_W * OUT_H - 1;

    typedef enum logic [2:0] {IDLE, WAIT_SOF, ACCUM, GO, BUSY} state_t;

    state_t state, nxt;
    logic [XW-1:0] x, cx, wx;
    logic [YW-1:0] y, cy, wy;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [ACC_W-1:0] acc [OUT_W];
    logic [ACC_W-1:0] sum;
    logic [7:0] mean, shaped;
    logic proc, in_win, blk_end, mb, inv, x_wrap;

    // Pixel position (a sof pixel is always x=0,y=0), window test and block mean
    always_comb begin
        cx      = pix_sof ? '0 : x;
        cy      = pix_sof ? '0 : y;
        proc    = en && pix_valid && ((state == WAIT_SOF && pix_sof) || state == ACCUM);
        in_win  = int'(cx) >= X_OFF && int'(cx) < X_OFF + OUT_W * BLOCK_W &&
                  int'(cy) >= Y_OFF && int'(cy) < Y_OFF + OUT_H * BLOCK_H;
        wx      = cx - XW'(X_OFF);
        wy      = cy - YW'(Y_OFF);
        col     = CW'(wx >> LBW);
        row     = RW'(wy >> LBH);
        blk_end = in_win && (&wx[LBW-1:0]) && (&wy[LBH-1:0]);
        sum     = acc[col] + ACC_W'(pix_data);
        mean    = sum[ACC_W-1:LB];
        shaped  = (mb ? (int'(mean) >= THRESHOLD ? 8'hFF : 8'h00) : mean) ^ {8{inv}};
        x_wrap  = cx == XW'(SCREEN_W - 1);
    end

    // Next state and state-decoded handshake outputs
    always_comb begin
        nxt        = state;
        frame_done = state == GO;
        infer_go   = state == GO;
        busy       = state == GO || state == BUSY;
        unique case (state)
            IDLE:     nxt = en ? WAIT_SOF : IDLE;
            WAIT_SOF: nxt = !en ? IDLE : (pix_valid && pix_sof) ? ACCUM : WAIT_SOF;
            ACCUM:    nxt = !en ? IDLE : (wr_en && wr_addr == AW'(LAST)) ? GO : ACCUM;
            GO:       nxt = BUSY;
            BUSY:     nxt = infer_done ? (en ? WAIT_SOF : IDLE) : BUSY;
            default:  nxt = IDLE;
        endcase
    end

    // State, raster counters, column accumulators, write port and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            mb       <= 1'b0;
            inv      <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            drop_cnt <= '0;
            for (int c = 0; c < OUT_W; c++) acc[c] <= '0;
        end else begin
            state <= nxt;
            wr_en <= proc && blk_end;
            if (proc && blk_end) begin
                wr_addr <= AW'(int'(row) * OUT_W + int'(col));
                wr_data <= shaped;
            end
            if (proc && pix_sof) begin
                mb  <= mode_bin;
                inv <= invert;
            end
            if (proc && int'(cy) < SCREEN_H) begin
                x <= x_wrap ? '0 : cx + 1'b1;
                y <= x_wrap ? cy + 1'b1 : cy;
            end
            if (state == BUSY && en && pix_valid && pix_sof && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
            for (int c = 0; c < OUT_W; c++)
                if (proc) begin
                    if (in_win && int'(col) == c)
                        acc[c] <= blk_end ? '0 : (pix_sof ? '0 : acc[c]) + ACC_W'(pix_data);
                    else if (pix_sof)
                        acc[c] <= '0;
                end
        end
    end
endmodule

// File: tb/tb_lenet_frame_pooler.sv
// tb_lenet_frame_pooler: directed checks of capture, averaging, modes, restart, drop and abort behaviour
module tb_lenet_frame_pooler;
    logic clk = 0, rst = 1, en = 0, mode_bin = 0, invert = 0;
    logic pix_valid = 0, pix_sof = 0, infer_done = 0;
    logic [7:0] pix_data = 0;
    logic wr_en, frame_done, infer_go, busy;
    logic [1:0] wr_addr;
    logic [7:0] wr_data, drop_cnt;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, nw = 0, nd = 0, fd_n = 0, go_n = 0, fd_cyc = 0, go_cyc = 0;
    int wa [256], wd [256], wc [256], dc [256];
    int base, dbase, fbase;

    lenet_frame_pooler #(
        .SCREEN_W(16), .SCREEN_H(8), .BLOCK_W(4), .BLOCK_H(4), .OUT_W(2), .OUT_H(2),
        .X_OFF(4), .Y_OFF(0), .THRESHOLD(96)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode_bin(mode_bin), .invert(invert),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
        .infer_go(infer_go), .infer_done(infer_done), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Log writes and handshake pulses away from the active edge
    always @(negedge clk) begin
        if (wr_en) begin
            wa[nw] <= int'(wr_addr);
            wd[nw] <= int'(wr_data);
            wc[nw] <= cyc;
            nw <= nw + 1;
        end
        if (frame_done) begin
            fd_n <= fd_n + 1;
            fd_cyc <= cyc;
        end
        if (infer_go) begin
            go_n <= go_n + 1;
            go_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pval(input int k, input int x, input int y);
        return k == 0 ? 8'd100 : k == 1 ? ((x < 8 && y < 4) ? 8'd95 : 8'd96) :
               k == 2 ? 8'(x * 16) : 8'd255;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int k, input int y0, input int y1);
        for (int y = y0; y < y1; y++)
            for (int x = 0; x < 16; x++) begin
                @(posedge clk);
                #1;
                pix_valid = 1;
                pix_sof = (x == 0 && y == 0);
                pix_data = pval(k, x, y);
                if (x >= 4 && x < 12 && x % 4 == 3 && y % 4 == 3) begin
                    dc[nd] = cyc;
                    nd++;
                end
            end
        @(posedge clk);
        #1;
        pix_valid = 0;
        pix_sof = 0;
    endtask

    task automatic check_frame(input string tag, input int b, input int d0, input int d1,
                               input int d2, input int d3);
        int d [4];
        d = '{d0, d1, d2, d3};
        chk({tag, "_count"}, nw - b, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wa[b+i], i);
            chk($sformatf("%s_data%0d", tag, i), wd[b+i], d[i]);
        end
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 infer_done = 1;
        @(posedge clk);
        #1 infer_done = 0;
        chk("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        idle(3);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_go", int'(infer_go), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_addr", int'(wr_addr), 0);
        chk("rst_data", int'(wr_data), 0);
        rst = 0;
        en = 1;
        idle(2);

        base = nw; fbase = fd_n;
        send(0, 0, 8); idle(6);
        check_frame("grey", base, 100, 100, 100, 100);
        chk("grey_fd_count", fd_n - fbase, 1);
        chk("grey_fd_time", fd_cyc, wc[base+3] + 1);
        chk("grey_go_time", go_cyc, wc[base+3] + 1);
        chk("grey_busy", int'(busy), 1);
        pulse_done();

        mode_bin = 1;
        base = nw; send(1, 0, 8); idle(6);
        check_frame("bin", base, 0, 255, 255, 255);
        pulse_done();
        invert = 1;
        base = nw; send(1, 0, 8); idle(6);
        check_frame("bin_inv", base, 255, 0, 0, 0);
        pulse_done();

        mode_bin = 0; invert = 0;
        base = nw; dbase = nd; send(2, 0, 8); idle(6);
        check_frame("ramp", base, 88, 152, 88, 152);
        for (int i = 0; i < 4; i++) chk($sformatf("ramp_lat%0d", i), wc[base+i], dc[dbase+i] + 1);
        pulse_done();
        base = nw; send(3, 0, 8); idle(6);
        check_frame("full255", base, 255, 255, 255, 255);
        pulse_done();

        base = nw; fbase = fd_n;
        send(3, 0, 2); send(0, 0, 8); idle(6);
        check_frame("restart", base, 100, 100, 100, 100);
        chk("restart_fd_count", fd_n - fbase, 1);

        base = nw;
        repeat (3) send(0, 0, 8);
        idle(4);
        chk("drop_cnt", int'(drop_cnt), 3);
        chk("drop_no_writes", nw - base, 0);
        pulse_done();
        base = nw; send(0, 0, 8); idle(6);
        check_frame("after_drop", base, 100, 100, 100, 100);

        pulse_done();
        base = nw; fbase = fd_n;
        send(0, 0, 6); idle(2);
        chk("abort_partial_writes", nw - base, 2);
        en = 0;
        idle(2);
        send(0, 6, 8); idle(6);
        chk("abort_writes", nw - base, 2);
        chk("abort_fd", fd_n - fbase, 0);
        chk("abort_busy", int'(busy), 0);

        en = 1;
        idle(2);
        base = nw; send(0, 0, 8); idle(6);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_writes", nw - base, 4);
        @(posedge clk);
        #1 rst = 1;
        @(posedge clk);
        #1;
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_drop", int'(drop_cnt), 0);
        chk("rst2_addr", int'(wr_addr), 0);
        chk("rst2_data", int'(wr_data), 0);
        chk("rst2_wr_en", int'(wr_en), 0);
        chk("rst2_go", int'(infer_go), 0);
        rst = 0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
